// File: rtl/sponge_pkg.sv
// Shared types and constants for the SHAKE sponge controller.
// The state encoding, lane/state widths and padding bytes live here.
package sponge_pkg;

    localparam int unsigned LANE_W  = 64;
    localparam int unsigned STATE_W = 1600;

    localparam logic [7:0] PAD_SHAKE = 8'h1F;
    localparam logic [7:0] PAD_SHA3  = 8'h06;
    localparam logic [7:0] PAD_LAST  = 8'h80;

    typedef enum logic [2:0] {
        StIdle,
        StAbsorb,
        StPermAbs,
        StSqueeze,
        StPermSqz
    } sponge_state_e;

endpackage

// File: rtl/sponge_pad_lane.sv
// Builds the XOR contribution of the last absorb beat: the valid low bytes of the
// beat followed by the domain pad byte at byte position nbytes_i.
module sponge_pad_lane
    import sponge_pkg::*;
(
    input  logic [LANE_W-1:0] data_i,
    input  logic [2:0]        nbytes_i,
    input  logic [7:0]        pad_i,
    output logic [LANE_W-1:0] lane_o
);

    logic [LANE_W-1:0] mask;
    logic [5:0]        shamt;

    always_comb begin
        shamt  = {nbytes_i, 3'b000};
        mask   = (LANE_W'(1) << shamt) - LANE_W'(1);
        lane_o = (data_i & mask) ^ (LANE_W'(pad_i) << shamt);
    end

endmodule

// File: rtl/shake_sponge_ctrl.sv
// SHAKE sponge controller: absorbs a 64-bit lane stream, drives an external
// Keccak-f[1600] core and squeezes lanes. Optional macro SHAKE_DOMAIN_SEL_EN adds sha3_mode.
module shake_sponge_ctrl
    import sponge_pkg::*;
#(
    parameter int unsigned RATE_LANES = 17
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
`ifdef SHAKE_DOMAIN_SEL_EN
    input  logic               sha3_mode,
`endif
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [LANE_W-1:0]  in_data,
    input  logic               in_last,
    input  logic [2:0]         in_bytes,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [LANE_W-1:0]  out_data,
    input  logic               squeeze_stop,
    output logic               perm_start,
    output logic [STATE_W-1:0] perm_state_in,
    input  logic [STATE_W-1:0] perm_state_out,
    input  logic               perm_done,
    output logic               busy
);

    localparam int unsigned LcW        = $clog2(RATE_LANES + 1);
    localparam logic [LcW-1:0] LastLane = LcW'(RATE_LANES - 1);
    localparam int unsigned PadLastBit = (RATE_LANES - 1) * LANE_W + LANE_W - 8;

    sponge_state_e      state_q, state_d;
    logic [STATE_W-1:0] s_q, s_d;
    logic [LcW-1:0]     lc_q, lc_d;
    logic               final_q, final_d;
    logic               perm_start_q, perm_start_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;

    logic [31:0]        lane_base;
    logic [LANE_W-1:0]  cur_lane;
    logic [LANE_W-1:0]  pad_lane;
    logic [STATE_W-1:0] pad_xor;
    logic [7:0]         pad_byte;

`ifdef SHAKE_DOMAIN_SEL_EN
    logic mode_q, mode_d;

    always_comb begin
        mode_d = mode_q;
        if (state_q == StIdle && start) begin
            mode_d = sha3_mode;
        end
    end

    assign pad_byte = mode_q ? PAD_SHA3 : PAD_SHAKE;
`else
    assign pad_byte = PAD_SHAKE;
`endif

    assign lane_base = 32'(lc_q) * LANE_W;
    assign cur_lane  = s_q[lane_base +: LANE_W];

    sponge_pad_lane u_pad_lane (
        .data_i   (in_data),
        .nbytes_i (in_bytes),
        .pad_i    (pad_byte),
        .lane_o   (pad_lane)
    );

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        lc_d    = lc_q;
        final_d = final_q;
        pad_xor = '0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    s_d     = '0;
                    lc_d    = '0;
                    final_d = 1'b0;
                    state_d = StAbsorb;
                end
            end
            StAbsorb: begin
                if (in_valid && in_ready_q) begin
                    if (in_last) begin
                        // Both pads go through one XOR vector so they combine when they overlap.
                        pad_xor[lane_base +: LANE_W] = pad_lane;
                        pad_xor[PadLastBit +: 8]     = pad_xor[PadLastBit +: 8] ^ PAD_LAST;
                        s_d     = s_q ^ pad_xor;
                        final_d = 1'b1;
                        state_d = StPermAbs;
                    end else begin
                        s_d[lane_base +: LANE_W] = cur_lane ^ in_data;
                        if (lc_q == LastLane) begin
                            lc_d    = '0;
                            final_d = 1'b0;
                            state_d = StPermAbs;
                        end else begin
                            lc_d = lc_q + LcW'(1);
                        end
                    end
                end
            end
            StPermAbs: begin
                if (perm_done) begin
                    s_d     = perm_state_out;
                    lc_d    = '0;
                    state_d = final_q ? StSqueeze : StAbsorb;
                end
            end
            StSqueeze: begin
                if (squeeze_stop) begin
                    state_d = StIdle;
                end else if (out_valid_q && out_ready) begin
                    if (lc_q == LastLane) begin
                        lc_d    = '0;
                        state_d = StPermSqz;
                    end else begin
                        lc_d = lc_q + LcW'(1);
                    end
                end
            end
            StPermSqz: begin
                if (squeeze_stop) begin
                    state_d = StIdle;
                end else if (perm_done) begin
                    s_d     = perm_state_out;
                    lc_d    = '0;
                    state_d = StSqueeze;
                end
            end
            default: state_d = StIdle;
        endcase

        perm_start_d = (state_d == StPermAbs && state_q != StPermAbs) ||
                       (state_d == StPermSqz && state_q != StPermSqz);
        in_ready_d   = (state_d == StAbsorb);
        out_valid_d  = (state_d == StSqueeze);
        busy_d       = (state_d != StIdle);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            s_q          <= '0;
            lc_q         <= '0;
            final_q      <= 1'b0;
            perm_start_q <= 1'b0;
            in_ready_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
`ifdef SHAKE_DOMAIN_SEL_EN
            mode_q       <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            s_q          <= s_d;
            lc_q         <= lc_d;
            final_q      <= final_d;
            perm_start_q <= perm_start_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            busy_q       <= busy_d;
`ifdef SHAKE_DOMAIN_SEL_EN
            mode_q       <= mode_d;
`endif
        end
    end

    assign in_ready      = in_ready_q;
    assign out_valid     = out_valid_q;
    assign out_data      = cur_lane;
    assign perm_start    = perm_start_q;
    assign perm_state_in = s_q;
    assign busy          = busy_q;

endmodule
